// File: rtl/dp_dmi_dr.sv
// DMI data register of the JTAG debug transport: scans {addr,data,op}, issues one DMI
// request per update and keeps a sticky error/busy status for DTMCS.
module dp_dmi_dr #(
    parameter int ABITS = 7,
    parameter int DBITS = 32
) (
    input  logic             tck,
    input  logic             trst,
    input  logic             sdi,
    output logic             sdo,
    input  logic             shift_dr,
    input  logic             clk_dr,
    input  logic             update_dr,
    input  logic             dmi_reset,
    input  logic             dmi_hardreset,
    output logic [1:0]       dmi_stat,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [DBITS-1:0] dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    input  logic [DBITS-1:0] dmi_resp_data,
    input  logic [1:0]       dmi_resp_op
);
    localparam int W = ABITS + DBITS + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state_q;
    logic [W-1:0]     sr_q;
    logic [1:0]       sticky_q;
    logic [1:0]       sticky_d;
    logic             req_valid_q;
    logic [ABITS-1:0] req_addr_q;
    logic [DBITS-1:0] req_data_q;
    logic [1:0]       req_op_q;
    logic [ABITS-1:0] last_addr_q;
    logic [DBITS-1:0] resp_data_q;

    logic       busy;
    logic [1:0] cap_op;
    logic       do_update;
    logic       do_clk;
    logic       accept;
    logic       resp_take;
    logic [1:0] err_code;

    always_comb begin
        busy      = (state_q != IDLE);
        cap_op    = (sticky_q != 2'd0) ? sticky_q : (busy ? 2'd3 : 2'd0);
        do_update = update_dr & ~dmi_hardreset & ~dmi_reset;
        // clk_dr is a no-op in an update cycle so the DR is not disturbed while issuing
        do_clk    = clk_dr & ~update_dr;
        accept    = do_update & ~busy & (sticky_q == 2'd0) &
                    ((sr_q[1:0] == 2'd1) || (sr_q[1:0] == 2'd2));
        resp_take = (state_q == WAIT) & dmi_resp_valid & ~dmi_hardreset;
        err_code  = 2'd0;
        if ((do_update & busy) | (do_clk & ~shift_dr & busy))
            err_code = 2'd3;
        else if (resp_take && dmi_resp_op != 2'd0)
            err_code = 2'd2;
        // First error sticks; clears win over any error raised in the same cycle
        sticky_d = sticky_q;
        if (dmi_hardreset || dmi_reset)
            sticky_d = 2'd0;
        else if (sticky_q == 2'd0)
            sticky_d = err_code;
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            sticky_q    <= 2'd0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_op_q    <= 2'd0;
            last_addr_q <= '0;
            resp_data_q <= '0;
        end else begin
            sticky_q <= sticky_d;
            if (do_clk) begin
                if (shift_dr)
                    sr_q <= {sdi, sr_q[W-1:1]};
                else
                    sr_q <= {last_addr_q, resp_data_q, cap_op};
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_addr_q  <= sr_q[W-1:DBITS+2];
                        req_data_q  <= sr_q[DBITS+1:2];
                        req_op_q    <= sr_q[1:0];
                        last_addr_q <= sr_q[W-1:DBITS+2];
                        req_valid_q <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (dmi_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_take) begin
                        if (req_op_q == 2'd1)
                            resp_data_q <= dmi_resp_data;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (dmi_hardreset) begin
                state_q     <= IDLE;
                req_valid_q <= 1'b0;
            end
        end
    end

    assign sdo           = sr_q[0];
    assign dmi_stat      = sticky_q;
    assign dmi_req_valid = req_valid_q;
    assign dmi_req_addr  = req_addr_q;
    assign dmi_req_data  = req_data_q;
    assign dmi_req_op    = req_op_q;

endmodule

// File: tb/tb_dp_dmi_dr.sv
// Bench for dp_dmi_dr: transaction-level model checked every cycle, plus directed literal checks.
module tb_dp_dmi_dr;
    localparam int AB = 7;
    localparam int W  = AB + 34;

    logic          tck = 1'b0;
    logic          trst = 1'b1;
    logic          sdi = 1'b0;
    logic          sdo;
    logic          shift_dr = 1'b0;
    logic          clk_dr = 1'b0;
    logic          update_dr = 1'b0;
    logic          dmi_reset = 1'b0;
    logic          dmi_hardreset = 1'b0;
    logic [1:0]    dmi_stat;
    logic          dmi_req_valid;
    logic          dmi_req_ready = 1'b0;
    logic [AB-1:0] dmi_req_addr;
    logic [31:0]   dmi_req_data;
    logic [1:0]    dmi_req_op;
    logic          dmi_resp_valid = 1'b0;
    logic [31:0]   dmi_resp_data = '0;
    logic [1:0]    dmi_resp_op = 2'd0;

    dp_dmi_dr #(.ABITS(AB), .DBITS(32)) dut (
        .tck(tck), .trst(trst), .sdi(sdi), .sdo(sdo),
        .shift_dr(shift_dr), .clk_dr(clk_dr), .update_dr(update_dr),
        .dmi_reset(dmi_reset), .dmi_hardreset(dmi_hardreset), .dmi_stat(dmi_stat),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_data(dmi_resp_data), .dmi_resp_op(dmi_resp_op)
    );

    always #5 tck = ~tck;

    int checks = 0;
    int failures = 0;

    // Model: 0 = idle, 1 = request offered, 2 = awaiting response
    int          m_phase;
    logic [W-1:0] m_sr;
    logic [1:0]  m_sticky;
    logic [AB-1:0] m_last_addr, m_req_addr;
    logic [31:0] m_resp_data, m_req_data;
    logic [1:0]  m_req_op;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_sr = '0; m_sticky = 2'd0; m_last_addr = '0; m_req_addr = '0;
        m_resp_data = '0; m_req_data = '0; m_req_op = 2'd0;
    endtask

    task automatic model_update(input logic u, input logic c, input logic s, input logic di,
                                input logic r, input logic h, input logic rv, input logic rdy,
                                input logic [31:0] rd, input logic [1:0] ro);
        int np;
        logic [1:0] err;
        np = m_phase;
        err = 2'd0;
        if (u && !h && !r) begin
            if (m_phase != 0) err = 2'd3;
            else if (m_sticky == 0 && (m_sr[1:0] == 2'd1 || m_sr[1:0] == 2'd2)) begin
                m_req_addr = m_sr[W-1:34];
                m_req_data = m_sr[33:2];
                m_req_op = m_sr[1:0];
                m_last_addr = m_sr[W-1:34];
                np = 1;
            end
        end else if (c && !u) begin
            if (s) m_sr = {di, m_sr[W-1:1]};
            else begin
                m_sr = {m_last_addr, m_resp_data,
                        (m_sticky != 0) ? m_sticky : ((m_phase != 0) ? 2'd3 : 2'd0)};
                if (m_phase != 0) err = 2'd3;
            end
        end
        if (m_phase == 1 && rdy) np = 2;
        if (m_phase == 2 && rv && !h) begin
            if (m_req_op == 2'd1) m_resp_data = rd;
            if (ro != 0 && err == 0) err = 2'd2;
            np = 0;
        end
        if (h) np = 0;
        if (h || r) m_sticky = 2'd0;
        else if (m_sticky == 0) m_sticky = err;
        m_phase = np;
    endtask

    task automatic step();
        logic u, c, s, di, r, h, rv, rdy;
        logic [31:0] rd;
        logic [1:0] ro;
        u = update_dr; c = clk_dr; s = shift_dr; di = sdi; r = dmi_reset; h = dmi_hardreset;
        rv = dmi_resp_valid; rdy = dmi_req_ready; rd = dmi_resp_data; ro = dmi_resp_op;
        @(posedge tck);
        #1;
        model_update(u, c, s, di, r, h, rv, rdy, rd, ro);
        clk_dr = 0; shift_dr = 0; update_dr = 0; dmi_reset = 0; dmi_hardreset = 0;
        dmi_resp_valid = 0;
    endtask

    task automatic scan(input logic [W-1:0] din, output logic [W-1:0] dout);
        clk_dr = 1; shift_dr = 0;
        step();
        for (int i = 0; i < W; i++) begin
            dout[i] = sdo;
            clk_dr = 1; shift_dr = 1; sdi = din[i];
            step();
        end
        sdi = 0;
    endtask

    task automatic update();
        update_dr = 1;
        step();
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] op);
        dmi_resp_valid = 1; dmi_resp_data = d; dmi_resp_op = op;
        step();
    endtask

    always @(negedge tck) begin
        chk("cyc_valid", dmi_req_valid, (m_phase == 1));
        chk("cyc_stat", dmi_stat, m_sticky);
        chk("cyc_addr", dmi_req_addr, m_req_addr);
        chk("cyc_data", dmi_req_data, m_req_data);
        chk("cyc_op", dmi_req_op, m_req_op);
        chk("cyc_sdo", sdo, m_sr[0]);
    end

    initial begin
        logic [W-1:0] d;
        model_reset();
        repeat (2) @(posedge tck);
        #1;
        chk("rst_valid", dmi_req_valid, 0);
        chk("rst_stat", dmi_stat, 0);
        chk("rst_sdo", sdo, 0);
        chk("rst_addr", dmi_req_addr, 0);
        trst = 0;
        step();

        // Write request, accepted immediately
        dmi_req_ready = 1;
        scan({7'h10, 32'hDEADBEEF, 2'd2}, d);
        update();
        chk("wr_valid", dmi_req_valid, 1);
        chk("wr_addr", dmi_req_addr, 7'h10);
        chk("wr_op", dmi_req_op, 2);
        chk("wr_data", dmi_req_data, 32'hDEADBEEF);
        step();
        chk("wr_valid_drop", dmi_req_valid, 0);
        respond(32'hFFFF0000, 2'd0);
        chk("wr_stat", dmi_stat, 0);

        // Read request, then scan out the result
        scan({7'h11, 32'h0, 2'd1}, d);
        chk("wr_keeps_data", d, {7'h10, 32'h0, 2'd0});
        update();
        step();
        respond(32'h12345678, 2'd0);
        scan('0, d);
        chk("rd_scan", d, {7'h11, 32'h12345678, 2'd0});

        // Busy: request stalled while captured and updated again
        dmi_req_ready = 0;
        scan({7'h22, 32'h0, 2'd1}, d);
        update();
        step(); step();
        scan({7'h23, 32'h1, 2'd2}, d);
        chk("busy_cap", d, {7'h22, 32'h12345678, 2'd3});
        chk("busy_stat", dmi_stat, 3);
        update();
        chk("busy_addr_kept", dmi_req_addr, 7'h22);
        chk("busy_valid_kept", dmi_req_valid, 1);
        dmi_reset = 1;
        step();
        chk("busy_reset_stat", dmi_stat, 0);
        dmi_req_ready = 1;
        step();
        chk("busy_done_valid", dmi_req_valid, 0);
        respond(32'hA5A50001, 2'd0);
        chk("busy_end_stat", dmi_stat, 0);
        scan('0, d);
        chk("busy_rd_scan", d, {7'h22, 32'hA5A50001, 2'd0});

        // Failed response
        scan({7'h05, 32'h77, 2'd2}, d);
        update();
        step();
        respond(32'h0, 2'd2);
        chk("fail_stat", dmi_stat, 2);
        scan({7'h06, 32'h1, 2'd2}, d);
        chk("fail_cap", d, {7'h05, 32'hA5A50001, 2'd2});
        update();
        chk("fail_no_req", dmi_req_valid, 0);
        step();
        chk("fail_no_req2", dmi_req_valid, 0);
        dmi_reset = 1;
        step();
        chk("fail_clear", dmi_stat, 0);

        // Hardreset while stalled in request
        dmi_req_ready = 0;
        scan({7'h33, 32'h9, 2'd2}, d);
        update();
        scan('0, d);
        chk("hr_busy_op", d[1:0], 3);
        chk("hr_valid_before", dmi_req_valid, 1);
        dmi_hardreset = 1;
        step();
        chk("hr_valid", dmi_req_valid, 0);
        chk("hr_stat", dmi_stat, 0);
        respond(32'hBAD0BAD0, 2'd2);
        chk("hr_late_stat", dmi_stat, 0);
        scan('0, d);
        chk("hr_scan", d, {7'h33, 32'hA5A50001, 2'd0});

        // Async reset during WAIT
        dmi_req_ready = 1;
        scan({7'h44, 32'h0, 2'd1}, d);
        update();
        step();
        #2 trst = 1;
        #1;
        model_reset();
        chk("trst_valid", dmi_req_valid, 0);
        chk("trst_stat", dmi_stat, 0);
        chk("trst_sdo", sdo, 0);
        chk("trst_addr", dmi_req_addr, 0);
        chk("trst_data", dmi_req_data, 0);
        chk("trst_op", dmi_req_op, 0);
        @(posedge tck);
        #1;
        trst = 0;
        respond(32'h55, 2'd0);
        scan('0, d);
        chk("trst_scan", d, 0);
        update();
        chk("op0_no_req", dmi_req_valid, 0);
        step();
        chk("op0_no_req2", dmi_req_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
